cv32e40x_rvfi_trace_serializer: RTL and testbench
=================================================

Name: cv32e40x_rvfi_trace_serializer

Overview:
Upstream feeder for the RVFI simulation tracer. Captures each retired-instruction RVFI record into a small record FIFO. Emits the record as one beat per active memory slot over a valid/ready interface. The downstream logger or trace-packer therefore receives exactly one line-sized beat per memory transfer, or one beat for a non-memory instruction. RVFI has no backpressure, so overflow is detected, counted and flagged rather than stalled.

Parameters:
NMEM, 4, number of RVFI memory slots per retirement (≥1)
DEPTH, 4, record FIFO depth in whole retirements (power of 2, ≥2)
DROP_CNT_W, 16, width of saturating dropped-record counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
rvfi_valid  input  1  retirement strobe, one record per cycle
rvfi_pc_rdata  input  32  retired PC
rvfi_rs1_addr / rvfi_rs2_addr / rvfi_rd_addr  input  5 each  register indices
rvfi_rs1_rdata / rvfi_rs2_rdata / rvfi_rd_wdata  input  32 each  register data
rvfi_mem_addr / rvfi_mem_rdata / rvfi_mem_wdata  input  32*NMEM each  per-slot memory fields
rvfi_mem_rmask / rvfi_mem_wmask  input  4*NMEM each  per-slot byte masks
out_valid  output  1  beat available
out_ready  input  1  consumer accepts beat
out_pc, out_rs1_addr, out_rs1_rdata, out_rs2_addr, out_rs2_rdata, out_rd_addr, out_rd_wdata  output  as inputs  head record fields, repeated on every beat
out_mem_addr / out_mem_rdata / out_mem_wdata  output  32 each  selected slot
out_mem_rmask / out_mem_wmask  output  4 each  selected slot masks
out_slot  output  $clog2(NMEM) (min 1)  slot index of beat
out_last  output  1  final beat of current record
level  output  $clog2(DEPTH+1)  records held, including the one being serialized
overflow  output  1  sticky: at least one record dropped
drop_cnt  output  DROP_CNT_W  dropped records, saturating

Behaviour:
- Reset (async assert, sync deassert handled externally): FIFO empty, level=0, out_valid=0, out_slot=0, out_last=0, all out_* data=0, overflow=0, drop_cnt=0. Reset mid-serialization discards all records and beats.
- Push: a record is written when rvfi_valid=1 and level<DEPTH.
  - If level==DEPTH, the record is dropped, overflow←1 and drop_cnt increments (holds at all-ones).
  - Fullness is evaluated on the pre-cycle level. A same-cycle pop of the last beat does not make room.
- Latency: a record pushed in cycle t into an empty FIFO gives out_valid=1 in cycle t+1. No combinational path exists from rvfi_* to out_*.
- Active slot: slot i is active iff |rmask[i] or |wmask[i].
- Beat sequence: active slots in ascending index order; inactive slots are skipped.
  - If no slot is active, emit a single beat with out_slot=0, mem addr/data/masks=0 and out_last=1.
- First beat of a record selects the lowest active slot. On handshake (out_valid&&out_ready) with out_last=0, advance to the next higher active slot.
- out_last=1 when no active slot exists above the current slot.
- Handshake with out_last=1: the record is popped and level decrements.
  - If the FIFO is non-empty after the pop, the next record's first beat is presented in the next cycle, with no bubble.
  - If the FIFO is empty after the pop, out_valid drops to 0.
- Simultaneous push and final-beat pop with level<DEPTH: both take effect and level is unchanged.
- While out_valid=1 and out_ready=0, all out_* signals are held stable.
- out_valid never deasserts without a handshake, except on reset.
- Pointers wrap modulo DEPTH. level distinguishes full from empty.
- X on rvfi_* while rvfi_valid=0 is ignored and must not propagate to outputs.

Test Plan:
- Non-memory instruction: rvfi_valid with pc=0x00000080, all masks 0, out_ready=1 -> next cycle a single beat: out_pc=0x00000080, out_last=1, out_mem_*=0, out_slot=0; level returns to 0.
- Sparse memops, NMEM=4: rmask=0x0F in slot 0, wmask=0x3 in slot 2 -> two beats: slot 0 (rmask 1111, last=0), then slot 2 (wmask 0011, last=1). Slots 1 and 3 are never emitted.
- Backpressure: out_ready=0 for 5 cycles on the slot-0 beat -> all outputs hold. Release -> slot 2 follows on the next cycle.
- Overflow: out_ready=0, 6 consecutive retirements with DEPTH=4 -> level=4, overflow=1, drop_cnt=2. Drain -> records 1-4 emitted in order.
- Full plus pop in the same cycle: level=4, final beat handshake while rvfi_valid=1 -> new record dropped, drop_cnt+1, level=3.
- Reset asserted mid-record, during the second beat -> out_valid=0 immediately. After release, level=0, overflow=0 and the next retirement starts cleanly.

Source files
------------

// File: rtl/cv32e40x_rvfi_trace_serializer.sv
// RVFI trace serializer: buffers retired-instruction records in a small FIFO
// and replays each one as one valid/ready beat per active memory slot.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   rvfi_*             retirement record, sampled when rvfi_valid=1
//   out_valid/ready    beat handshake
//   out_*              head record fields plus the selected memory slot
//   out_slot/out_last  slot index of the beat, final beat of the record
//   level              records held, including the one being serialized
//   overflow/drop_cnt  sticky drop flag and saturating drop counter
module cv32e40x_rvfi_trace_serializer #(
    parameter int NMEM       = 4,
    parameter int DEPTH      = 4,
    parameter int DROP_CNT_W = 16,
    localparam int SW        = (NMEM > 1) ? $clog2(NMEM) : 1,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rvfi_valid,
    input  logic [31:0]           rvfi_pc_rdata,
    input  logic [4:0]            rvfi_rs1_addr,
    input  logic [4:0]            rvfi_rs2_addr,
    input  logic [4:0]            rvfi_rd_addr,
    input  logic [31:0]           rvfi_rs1_rdata,
    input  logic [31:0]           rvfi_rs2_rdata,
    input  logic [31:0]           rvfi_rd_wdata,
    input  logic [32*NMEM-1:0]    rvfi_mem_addr,
    input  logic [32*NMEM-1:0]    rvfi_mem_rdata,
    input  logic [32*NMEM-1:0]    rvfi_mem_wdata,
    input  logic [4*NMEM-1:0]     rvfi_mem_rmask,
    input  logic [4*NMEM-1:0]     rvfi_mem_wmask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [4:0]            out_rs1_addr,
    output logic [31:0]           out_rs1_rdata,
    output logic [4:0]            out_rs2_addr,
    output logic [31:0]           out_rs2_rdata,
    output logic [4:0]            out_rd_addr,
    output logic [31:0]           out_rd_wdata,
    output logic [31:0]           out_mem_addr,
    output logic [31:0]           out_mem_rdata,
    output logic [31:0]           out_mem_wdata,
    output logic [3:0]            out_mem_rmask,
    output logic [3:0]            out_mem_wmask,
    output logic [SW-1:0]         out_slot,
    output logic                  out_last,
    output logic [LW-1:0]         level,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]        pc_q     [DEPTH];
    logic [4:0]         rs1a_q   [DEPTH];
    logic [4:0]         rs2a_q   [DEPTH];
    logic [4:0]         rda_q    [DEPTH];
    logic [31:0]        rs1d_q   [DEPTH];
    logic [31:0]        rs2d_q   [DEPTH];
    logic [31:0]        rdd_q    [DEPTH];
    logic [32*NMEM-1:0] maddr_q  [DEPTH];
    logic [32*NMEM-1:0] mrdata_q [DEPTH];
    logic [32*NMEM-1:0] mwdata_q [DEPTH];
    logic [4*NMEM-1:0]  rmask_q  [DEPTH];
    logic [4*NMEM-1:0]  wmask_q  [DEPTH];

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [LW-1:0]         level_q;
    logic [SW-1:0]         cur_slot;
    logic                  mid;
    logic                  overflow_q;
    logic [DROP_CNT_W-1:0] drop_q;

    logic            empty;
    logic            full;
    logic [NMEM-1:0] act;
    logic [SW-1:0]   first;
    logic [SW-1:0]   sel;
    logic [SW-1:0]   nxt;
    logic            has_next;
    logic            sel_act;
    logic            hs;
    logic            pop;
    logic            push;
    logic            drop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));

    // Active-slot map of the head record; forced to zero when empty so
    // stale or uninitialised storage never reaches the outputs.
    always_comb begin
        act = '0;
        for (int i = 0; i < NMEM; i++) begin
            act[i] = !empty && ((|rmask_q[rptr][4*i +: 4]) ||
                                (|wmask_q[rptr][4*i +: 4]));
        end
    end

    // First beat uses the lowest active slot; later beats use cur_slot.
    always_comb begin
        first = '0;
        for (int i = NMEM - 1; i >= 0; i--) begin
            if (act[i]) first = SW'(i);
        end
        sel      = mid ? cur_slot : first;
        nxt      = sel;
        has_next = 1'b0;
        for (int i = NMEM - 1; i >= 0; i--) begin
            if (act[i] && (i > int'(sel))) begin
                nxt      = SW'(i);
                has_next = 1'b1;
            end
        end
    end

    assign sel_act = act[sel];

    assign out_valid     = !empty;
    assign out_pc        = empty ? '0 : pc_q[rptr];
    assign out_rs1_addr  = empty ? '0 : rs1a_q[rptr];
    assign out_rs2_addr  = empty ? '0 : rs2a_q[rptr];
    assign out_rd_addr   = empty ? '0 : rda_q[rptr];
    assign out_rs1_rdata = empty ? '0 : rs1d_q[rptr];
    assign out_rs2_rdata = empty ? '0 : rs2d_q[rptr];
    assign out_rd_wdata  = empty ? '0 : rdd_q[rptr];
    assign out_mem_addr  = sel_act ? maddr_q[rptr][32*sel +: 32] : '0;
    assign out_mem_rdata = sel_act ? mrdata_q[rptr][32*sel +: 32] : '0;
    assign out_mem_wdata = sel_act ? mwdata_q[rptr][32*sel +: 32] : '0;
    assign out_mem_rmask = sel_act ? rmask_q[rptr][4*sel +: 4] : '0;
    assign out_mem_wmask = sel_act ? wmask_q[rptr][4*sel +: 4] : '0;
    assign out_slot      = empty ? '0 : sel;
    assign out_last      = !empty && !has_next;

    assign level    = level_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;

    // Fullness is judged on the pre-cycle level: a final-beat pop in the
    // same cycle does not open a slot for an incoming record.
    assign hs   = out_valid && out_ready;
    assign pop  = hs && out_last;
    assign push = rvfi_valid && !full;
    assign drop = rvfi_valid && full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            level_q    <= '0;
            cur_slot   <= '0;
            mid        <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
            if (hs) begin
                if (out_last) begin
                    mid      <= 1'b0;
                    cur_slot <= '0;
                end else begin
                    mid      <= 1'b1;
                    cur_slot <= nxt;
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) drop_q <= drop_q + DROP_CNT_W'(1);
            end
        end
    end

    // Record storage needs no reset: it is only visible while level>0.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wptr]     <= rvfi_pc_rdata;
            rs1a_q[wptr]   <= rvfi_rs1_addr;
            rs2a_q[wptr]   <= rvfi_rs2_addr;
            rda_q[wptr]    <= rvfi_rd_addr;
            rs1d_q[wptr]   <= rvfi_rs1_rdata;
            rs2d_q[wptr]   <= rvfi_rs2_rdata;
            rdd_q[wptr]    <= rvfi_rd_wdata;
            maddr_q[wptr]  <= rvfi_mem_addr;
            mrdata_q[wptr] <= rvfi_mem_rdata;
            mwdata_q[wptr] <= rvfi_mem_wdata;
            rmask_q[wptr]  <= rvfi_mem_rmask;
            wmask_q[wptr]  <= rvfi_mem_wmask;
        end
    end

endmodule

// File: tb/tb_cv32e40x_rvfi_trace_serializer.sv
// Self-checking bench for cv32e40x_rvfi_trace_serializer (NMEM=4, DEPTH=4):
// vector table for beat splitting plus sequences for backpressure,
// overflow, full-with-pop and mid-record reset, against a beat scoreboard.
module tb_cv32e40x_rvfi_trace_serializer;

    localparam int NMEM  = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1a;
        logic [31:0] rs1d;
        logic [4:0]  rs2a;
        logic [31:0] rs2d;
        logic [4:0]  rda;
        logic [31:0] rdd;
        logic [31:0] ma;
        logic [31:0] mr;
        logic [31:0] mw;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [1:0]  slot;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] rm;
        logic [15:0] wm;
        int          beats;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         rvfi_valid;
    logic [31:0]  rvfi_pc_rdata;
    logic [4:0]   rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [31:0]  rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [127:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [15:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic         out_valid, out_ready;
    logic [31:0]  out_pc, out_rs1_rdata, out_rs2_rdata, out_rd_wdata;
    logic [4:0]   out_rs1_addr, out_rs2_addr, out_rd_addr;
    logic [31:0]  out_mem_addr, out_mem_rdata, out_mem_wdata;
    logic [3:0]   out_mem_rmask, out_mem_wmask;
    logic [1:0]   out_slot;
    logic         out_last;
    logic [2:0]   level;
    logic         overflow;
    logic [15:0]  drop_cnt;

    cv32e40x_rvfi_trace_serializer #(
        .NMEM(NMEM), .DEPTH(DEPTH), .DROP_CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .rvfi_valid(rvfi_valid), .rvfi_pc_rdata(rvfi_pc_rdata),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
        .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_addr(out_rs1_addr),
        .out_rs1_rdata(out_rs1_rdata), .out_rs2_addr(out_rs2_addr),
        .out_rs2_rdata(out_rs2_rdata), .out_rd_addr(out_rd_addr),
        .out_rd_wdata(out_rd_wdata), .out_mem_addr(out_mem_addr),
        .out_mem_rdata(out_mem_rdata), .out_mem_wdata(out_mem_wdata),
        .out_mem_rmask(out_mem_rmask), .out_mem_wmask(out_mem_wmask),
        .out_slot(out_slot), .out_last(out_last), .level(level),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    int    beats_seen = 0;
    int    mlevel = 0;
    int    mdrop = 0;
    logic  mover = 1'b0;
    beat_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_beat(input beat_t act, input beat_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL beat: got %h required %h", act, exp);
        end
    endtask

    // Expand the record currently on the rvfi_* pins into expected beats.
    task automatic model_push();
        beat_t tmp[4];
        beat_t b;
        int    n = 0;
        b = '0;
        b.pc   = rvfi_pc_rdata;
        b.rs1a = rvfi_rs1_addr;  b.rs1d = rvfi_rs1_rdata;
        b.rs2a = rvfi_rs2_addr;  b.rs2d = rvfi_rs2_rdata;
        b.rda  = rvfi_rd_addr;   b.rdd  = rvfi_rd_wdata;
        for (int s = 0; s < NMEM; s++) begin
            if (rvfi_mem_rmask[4*s +: 4] != 0 ||
                rvfi_mem_wmask[4*s +: 4] != 0) begin
                tmp[n]      = b;
                tmp[n].ma   = rvfi_mem_addr[32*s +: 32];
                tmp[n].mr   = rvfi_mem_rdata[32*s +: 32];
                tmp[n].mw   = rvfi_mem_wdata[32*s +: 32];
                tmp[n].rm   = rvfi_mem_rmask[4*s +: 4];
                tmp[n].wm   = rvfi_mem_wmask[4*s +: 4];
                tmp[n].slot = 2'(s);
                n++;
            end
        end
        if (n == 0) begin
            tmp[0] = b;
            n = 1;
        end
        tmp[n-1].last = 1'b1;
        for (int k = 0; k < n; k++) exp_q.push_back(tmp[k]);
    endtask

    // Scoreboard: sampled on the falling edge, models the coming rise.
    always @(negedge clk) begin
        beat_t act;
        logic  hs, pop, full;
        if (rst) begin
            exp_q.delete();
            mlevel = 0;
            mdrop  = 0;
            mover  = 1'b0;
        end else begin
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            check("level", 64'(level), 64'(mlevel));
            check("overflow", 64'(overflow), 64'(mover));
            check("drop_cnt", 64'(drop_cnt), 64'(mdrop));
            act = {out_pc, out_rs1_addr, out_rs1_rdata, out_rs2_addr,
                   out_rs2_rdata, out_rd_addr, out_rd_wdata,
                   out_mem_addr, out_mem_rdata, out_mem_wdata,
                   out_mem_rmask, out_mem_wmask, out_slot, out_last};
            full = (mlevel == DEPTH);
            hs   = out_ready && exp_q.size() != 0;
            pop  = 1'b0;
            if (exp_q.size() != 0) begin
                check_beat(act, exp_q[0]);
                pop = hs && exp_q[0].last;
            end
            if (hs) begin
                void'(exp_q.pop_front());
                beats_seen++;
            end
            if (rvfi_valid) begin
                if (!full) begin
                    model_push();
                    mlevel++;
                end else begin
                    mover = 1'b1;
                    if (mdrop != 16'hFFFF) mdrop++;
                end
            end
            if (pop) mlevel--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rvfi_valid     = 1'b0;
        rvfi_pc_rdata  = 'x;
        rvfi_rs1_addr  = 'x; rvfi_rs2_addr  = 'x; rvfi_rd_addr  = 'x;
        rvfi_rs1_rdata = 'x; rvfi_rs2_rdata = 'x; rvfi_rd_wdata = 'x;
        rvfi_mem_addr  = 'x; rvfi_mem_rdata = 'x; rvfi_mem_wdata = 'x;
        rvfi_mem_rmask = 'x; rvfi_mem_wmask = 'x;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [15:0] rm,
                         input logic [15:0] wm);
        rvfi_valid     = 1'b1;
        rvfi_pc_rdata  = pc;
        rvfi_rs1_addr  = pc[6:2];
        rvfi_rs2_addr  = pc[11:7];
        rvfi_rd_addr   = pc[4:0] ^ 5'h1f;
        rvfi_rs1_rdata = pc ^ 32'h1111_1111;
        rvfi_rs2_rdata = pc ^ 32'h2222_2222;
        rvfi_rd_wdata  = pc + 32'h33;
        for (int s = 0; s < NMEM; s++) begin
            rvfi_mem_addr[32*s +: 32]  = pc + 32'h1000 + 32'(s * 4);
            rvfi_mem_rdata[32*s +: 32] = ~pc + 32'(s);
            rvfi_mem_wdata[32*s +: 32] = pc * 3 + 32'(s);
        end
        rvfi_mem_rmask = rm;
        rvfi_mem_wmask = wm;
    endtask

    task automatic wait_empty(input int lim);
        for (int i = 0; i < lim && exp_q.size() != 0; i++) tick();
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{32'h0000_0080, 16'h0000, 16'h0000, 1};
        tbl[1] = '{32'h0000_0100, 16'h000F, 16'h0300, 2};
        tbl[2] = '{32'h0000_0200, 16'h1111, 16'h0000, 4};
        tbl[3] = '{32'h0000_0204, 16'h0000, 16'hF000, 1};
        tbl[4] = '{32'h0000_0208, 16'h3000, 16'h00C0, 2};
        tbl[5] = '{32'h0000_020C, 16'h0000, 16'h0001, 1};

        rst = 1'b1;
        out_ready = 1'b0;
        idle();
        repeat (3) tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_slot", 64'(out_slot), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_maddr", 64'(out_mem_addr), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        for (int v = 0; v < 6; v++) begin
            int b0;
            b0 = beats_seen;
            tick();
            drive(tbl[v].pc, tbl[v].rm, tbl[v].wm);
            tick();
            idle();
            wait_empty(20);
            check("beat_count", 64'(beats_seen - b0), 64'(tbl[v].beats));
        end

        // Backpressure on the first beat of a sparse record.
        out_ready = 1'b0;
        tick();
        drive(32'h0000_0500, 16'h000F, 16'h0300);
        tick();
        idle();
        repeat (6) tick();
        check("bp_slot", 64'(out_slot), 64'd0);
        out_ready = 1'b1;
        tick();
        check("bp_next_slot", 64'(out_slot), 64'd2);
        wait_empty(10);

        // Six retirements into a depth-4 FIFO with the consumer stalled.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            drive(32'h0000_1000 + 32'(k * 4), 16'h0000, 16'h0000);
        end
        tick();
        idle();
        @(negedge clk);
        check("ovf_level", 64'(level), 64'd4);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drop", 64'(drop_cnt), 64'd2);
        tick();
        out_ready = 1'b1;
        wait_empty(20);

        // Full FIFO, final-beat pop and retirement in the same cycle.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            drive(32'h0000_2000 + 32'(k * 4), 16'h0000, 16'h0000);
        end
        tick();
        drive(32'h0000_2100, 16'h0000, 16'h0000);
        out_ready = 1'b1;
        tick();
        idle();
        out_ready = 1'b0;
        @(negedge clk);
        check("fp_level", 64'(level), 64'd3);
        check("fp_drop", 64'(drop_cnt), 64'd3);
        tick();
        out_ready = 1'b1;
        wait_empty(20);

        // Reset while the second beat of a record is presented.
        out_ready = 1'b0;
        tick();
        drive(32'h0000_0300, 16'hFFFF, 16'h0000);
        tick();
        idle();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("mid_slot", 64'(out_slot), 64'd1);
        rst = 1'b1;
        #1;
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_slot", 64'(out_slot), 64'd0);
        check("mr_level", 64'(level), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        check("mr_ovf", 64'(overflow), 64'd0);
        check("mr_drop", 64'(drop_cnt), 64'd0);
        out_ready = 1'b1;
        tick();
        drive(32'h0000_0400, 16'h0000, 16'h0000);
        tick();
        idle();
        wait_empty(10);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
